// File: rtl/interrupt_queue.sv
// rtl/interrupt_queue.sv - multi-channel interrupt queue: per-channel slots, round-robin arbiter, shared FWFT FIFO
module interrupt_queue #(
    parameter  int NUM_CHANNELS = 4,
    parameter  int VALUE_WIDTH  = 16,
    parameter  int DEPTH        = 10,
    localparam int ID_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             irq_valid,
    input  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] irq_value,
    input  logic [NUM_CHANNELS-1:0]             irq_mask,
    input  logic                                pop,
    input  logic [NUM_CHANNELS-1:0]             overflow_clear,
    output logic                                pending,
    output logic [ID_W-1:0]                     head_id,
    output logic [VALUE_WIDTH-1:0]              head_value,
    output logic [CNT_W-1:0]                    count,
    output logic [NUM_CHANNELS-1:0]             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_W + VALUE_WIDTH;

    logic [NUM_CHANNELS-1:0] r_slot_full;
    logic [VALUE_WIDTH-1:0]  r_slot_val [NUM_CHANNELS];
    logic [ID_W-1:0]         r_rr;
    logic [ENT_W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr;
    logic [PTR_W-1:0]        r_rd;
    logic [CNT_W-1:0]        r_count;
    logic [NUM_CHANNELS-1:0] r_overflow;

    logic                    w_pop_eff;
    logic                    w_found;
    logic                    w_grant;
    logic [ID_W-1:0]         w_grant_id;
    logic [ID_W-1:0]         w_scan_id;
    logic [ID_W-1:0]         w_rr_next;
    logic [PTR_W-1:0]        w_wr_next;
    logic [PTR_W-1:0]        w_rd_next;
    logic [NUM_CHANNELS-1:0] w_req;
    logic [NUM_CHANNELS-1:0] w_hit;
    logic [NUM_CHANNELS-1:0] w_load;
    logic [NUM_CHANNELS-1:0] w_loss;
    logic [ENT_W-1:0]        w_head;

    assign w_pop_eff = pop & (r_count != '0);

    // Rotating search: first full slot at or after r_rr wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_scan_id  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_scan_id = ID_W'((int'(r_rr) + i) % NUM_CHANNELS);
            if (!w_found && r_slot_full[w_scan_id]) begin
                w_found    = 1'b1;
                w_grant_id = w_scan_id;
            end
        end
    end

    // A full FIFO still accepts a grant when the head is popped in the same cycle.
    assign w_grant   = w_found & ((r_count < CNT_W'(DEPTH)) | pop);
    assign w_rr_next = (w_grant_id == ID_W'(NUM_CHANNELS - 1)) ? '0 : w_grant_id + ID_W'(1);
    assign w_wr_next = (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
    assign w_rd_next = (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);

    always_comb begin
        w_req  = '0;
        w_hit  = '0;
        w_load = '0;
        w_loss = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_req[c]  = irq_valid[c] & irq_mask[c];
            w_hit[c]  = w_grant && (w_grant_id == ID_W'(c));
            w_load[c] = w_req[c] & (~r_slot_full[c] | w_hit[c]);
            w_loss[c] = w_req[c] & r_slot_full[c] & ~w_hit[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_full <= '0;
            r_rr        <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_overflow  <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_load[c]) begin
                    r_slot_full[c] <= 1'b1;
                end else if (w_hit[c]) begin
                    r_slot_full[c] <= 1'b0;
                end
            end
            r_overflow <= w_loss | (r_overflow & ~overflow_clear);
            if (w_grant) begin
                r_rr <= w_rr_next;
                r_wr <= w_wr_next;
            end
            if (w_pop_eff) begin
                r_rd <= w_rd_next;
            end
            if (w_grant && !w_pop_eff) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_grant && w_pop_eff) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: validity lives in r_slot_full and r_count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_load[c]) begin
                    r_slot_val[c] <= irq_value[c*VALUE_WIDTH +: VALUE_WIDTH];
                end
            end
            if (w_grant) begin
                r_mem[r_wr] <= {w_grant_id, r_slot_val[w_grant_id]};
            end
        end
    end

    assign w_head     = r_mem[r_rd];
    assign pending    = (r_count != '0);
    assign head_id    = pending ? w_head[ENT_W-1 -: ID_W] : '0;
    assign head_value = pending ? w_head[VALUE_WIDTH-1:0] : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_interrupt_queue.sv
// tb/tb_interrupt_queue.sv - directed scoreboard bench for interrupt_queue
module tb_interrupt_queue;

    localparam int NC    = 4;
    localparam int VW    = 16;
    localparam int DEPTH = 10;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    irq_valid;
    logic [NC*VW-1:0] irq_value;
    logic [NC-1:0]    irq_mask;
    logic             pop;
    logic [NC-1:0]    overflow_clear;
    logic             pending;
    logic [ID_W-1:0]  head_id;
    logic [VW-1:0]    head_value;
    logic [CNT_W-1:0] count;
    logic [NC-1:0]    overflow;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [VW-1:0]   val;
    } entry_t;

    entry_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    interrupt_queue #(.NUM_CHANNELS(NC), .VALUE_WIDTH(VW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_valid      (irq_valid),
        .irq_value      (irq_value),
        .irq_mask       (irq_mask),
        .pop            (pop),
        .overflow_clear (overflow_clear),
        .pending        (pending),
        .head_id        (head_id),
        .head_value     (head_value),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int ch, input logic [VW-1:0] v);
        irq_valid     = '0;
        irq_valid[ch] = 1'b1;
        irq_value[ch*VW +: VW] = v;
    endtask

    task automatic expect_entry(input int ch, input logic [VW-1:0] v);
        sb_q.push_back({ID_W'(ch), v});
    endtask

    task automatic pop_check(input string tag);
        entry_t e;
        check({tag, " pending"}, 32'(pending), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " head_id"}, 32'(head_id), 32'(e.id));
            check({tag, " head_value"}, 32'(head_value), 32'(e.val));
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic fill(input int ch, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            post(ch, VW'(base + i));
            expect_entry(ch, VW'(base + i));
            tick();
        end
        irq_valid = '0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        irq_valid      = '0;
        pop            = 1'b0;
        overflow_clear = '0;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        irq_value = '0;
        irq_mask  = '1;
        do_reset();
        check("reset count", 32'(count), 0);
        check("reset pending", 32'(pending), 0);
        check("reset head_id", 32'(head_id), 0);
        check("reset head_value", 32'(head_value), 0);
        check("reset overflow", 32'(overflow), 0);

        // single request latency
        post(0, 16'h00A5);
        expect_entry(0, 16'h00A5);
        tick();
        irq_valid = '0;
        check("t1 pending after N", 32'(pending), 0);
        tick();
        check("t1 pending after N+1", 32'(pending), 1);
        check("t1 count", 32'(count), 1);
        pop_check("t1 pop");
        check("t1 empty pending", 32'(pending), 0);
        check("t1 empty head_id", 32'(head_id), 0);
        check("t1 empty head_value", 32'(head_value), 0);

        // all four at once, then a late ch0 request shows rr moved past it
        do_reset();
        irq_valid = 4'b1111;
        irq_value = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        expect_entry(0, 16'h0011);
        expect_entry(1, 16'h0022);
        expect_entry(2, 16'h0033);
        expect_entry(3, 16'h0044);
        tick();
        irq_valid = '0;
        tick();
        tick();
        post(0, 16'h0055);
        expect_entry(0, 16'h0055);
        tick();
        irq_valid = '0;
        tick();
        tick();
        check("t2 count", 32'(count), 5);
        for (int i = 0; i < 5; i++) pop_check("t2 rr order");
        check("t2 drained", 32'(count), 0);

        // fill to DEPTH, 11th held in slot, pop+grant keeps count at DEPTH
        do_reset();
        fill(0, 100, 11);
        tick();
        tick();
        check("t3 full count", 32'(count), DEPTH);
        check("t3 no overflow", 32'(overflow), 0);
        pop_check("t3 pop at full");
        check("t3 count after pop+grant", 32'(count), DEPTH);
        for (int i = 0; i < 10; i++) pop_check("t3 drain");
        check("t3 drained", 32'(count), 0);

        // overflow set, set-beats-clear, clear alone
        do_reset();
        fill(0, 200, 10);
        post(2, 16'h0222);
        expect_entry(2, 16'h0222);
        tick();
        post(2, 16'h0333);
        tick();
        irq_valid = '0;
        check("t4 overflow set", 32'(overflow), 32'b0100);
        check("t4 count full", 32'(count), DEPTH);
        post(2, 16'h0444);
        overflow_clear = 4'b0100;
        tick();
        irq_valid = '0;
        check("t4 set wins over clear", 32'(overflow), 32'b0100);
        tick();
        overflow_clear = '0;
        check("t4 clear alone", 32'(overflow), 0);
        for (int i = 0; i < 11; i++) pop_check("t4 drain");
        check("t4 drained", 32'(count), 0);

        // masked strobe is dropped; reset mid-traffic clears everything
        irq_mask = 4'b1110;
        post(0, 16'h0077);
        tick();
        irq_valid = '0;
        tick();
        tick();
        check("t5 masked count", 32'(count), 0);
        check("t5 masked pending", 32'(pending), 0);
        check("t5 masked overflow", 32'(overflow), 0);
        irq_mask = 4'b1111;
        fill(1, 300, 5);
        tick();
        check("t5 count5", 32'(count), 5);
        irq_valid = 4'b1111;
        tick();
        reset     = 1'b1;
        irq_valid = '0;
        tick();
        check("t5 reset count", 32'(count), 0);
        check("t5 reset pending", 32'(pending), 0);
        check("t5 reset head_value", 32'(head_value), 0);
        check("t5 reset overflow", 32'(overflow), 0);
        reset = 1'b0;
        sb_q.delete();
        tick();
        tick();
        tick();
        check("t5 slots cleared", 32'(count), 0);

        // pop on empty, then pop+grant at full across pointer wrap
        post(3, 16'h0333);
        expect_entry(3, 16'h0333);
        pop = 1'b1;
        tick();
        irq_valid = '0;
        check("t6 no underflow", 32'(count), 0);
        tick();
        pop = 1'b0;
        check("t6 push wins at empty", 32'(count), 1);
        pop_check("t6 ch3 entry");
        fill(1, 400, 10);
        post(2, 16'h0555);
        expect_entry(2, 16'h0555);
        tick();
        irq_valid = '0;
        tick();
        check("t6 full count", 32'(count), DEPTH);
        pop_check("t6 pop+grant");
        check("t6 count stays full", 32'(count), DEPTH);
        for (int i = 0; i < 10; i++) pop_check("t6 wrap drain");
        check("t6 drained count", 32'(count), 0);
        check("t6 drained pending", 32'(pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
